wb_timer: RTL and testbench

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_pkg.sv | 28 ++
 rtl/wishbone_bus.sv | 32 +++
 rtl/wb_timer_prescaler.sv | 33 +++
 rtl/wb_timer.sv | 165 ++++++++++++++++
 tb/tb_wb_timer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_pkg
// Brief    : Register map, field positions and reset values for wb_timer
// Revision : 1.0
// ============================================================================
package wb_timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_COUNT   = 3'd1,
        REG_COMPARE = 3'd2,
        REG_STATUS  = 3'd3
    } reg_idx_e;

    localparam int   c_ctrl_en_bit       = 0;
    localparam int   c_ctrl_auto_bit     = 1;
    localparam int   c_ctrl_irq_en_bit   = 2;
    localparam int   c_ctrl_psc_lsb      = 8;
    localparam int   c_status_match_bit  = 0;

    localparam logic c_ctrl_field_rst    = 1'b0;
    localparam logic c_count_rst_fill    = 1'b0;
    localparam logic c_compare_rst_fill  = 1'b1;
    localparam logic c_status_match_rst  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/wishbone_bus.sv
`default_nettype none
// ============================================================================
// Module   : Wishbone_bus
// Brief    : Pipelined Wishbone bus bundle with master and slave views
// Revision : 1.0
// ============================================================================
interface Wishbone_bus #(
    parameter int WIDTH = 32
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WIDTH-1:0]     adr;
    logic [WIDTH/8-1:0]   sel;
    logic [WIDTH-1:0]     dat_mosi;
    logic [WIDTH-1:0]     dat_miso;
    logic                 ack;
    logic                 err;
    logic                 stall;
    logic                 rty;

    modport S (
        input  cyc, stb, we, adr, sel, dat_mosi,
        output dat_miso, ack, err, stall, rty
    );

    modport M (
        output cyc, stb, we, adr, sel, dat_mosi,
        input  dat_miso, ack, err, stall, rty
    );
endinterface
`default_nettype wire

// File: rtl/wb_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_prescaler
// Brief    : Divides clk by (prescale+1) into a one-cycle tick while enabled
// Revision : 1.0
// ============================================================================
module wb_timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PSC_W-1:0] prescale,
    input  logic             restart,
    output logic             tick
);

    logic [PSC_W-1:0] r_cnt;

    assign tick = en & (r_cnt == prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer
// Brief    : Wishbone slave timer: prescaled counter, compare match and irq
// Revision : 1.0
// ============================================================================
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PSC_W = 8
) (
    input  logic   clk,
    input  logic   rst,
    Wishbone_bus.S bus,
    output logic   irq
);

    reg_idx_e         w_idx;
    logic             w_req;
    logic             w_mapped;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_compare;
    logic             w_match_set;
    logic             w_match_clr;
    logic             w_psc_restart;
    logic             w_tick;
    logic             w_ack;
    logic             w_unused;
    logic [WIDTH-1:0] w_ctrl_word;
    logic [WIDTH-1:0] w_ctrl_new;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_count_tick;
    logic [PSC_W-1:0] w_psc_new;

    logic             r_en;
    logic             r_auto;
    logic             r_irq_en;
    logic [PSC_W-1:0] r_psc;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_compare;
    logic             r_match;
    logic             r_irq;
    logic             r_ack;
    logic             r_err;
    logic [WIDTH-1:0] r_dat;

    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0]   old_val,
        input logic [WIDTH-1:0]   new_val,
        input logic [WIDTH/8-1:0] sel
    );
        logic [WIDTH-1:0] v_res;
        v_res = old_val;
        for (int b = 0; b < WIDTH/8; b++) begin
            if (sel[b]) begin
                v_res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return v_res;
    endfunction

    assign w_req        = bus.cyc & bus.stb;
    assign w_idx        = reg_idx_e'(bus.adr[4:2]);
    assign w_mapped     = (bus.adr[1:0] == 2'b00) & ~bus.adr[4];
    assign w_wr         = w_req & w_mapped & bus.we & (|bus.sel);
    assign w_wr_ctrl    = w_wr & (w_idx == REG_CTRL);
    assign w_wr_count   = w_wr & (w_idx == REG_COUNT);
    assign w_wr_compare = w_wr & (w_idx == REG_COMPARE);
    assign w_match_clr  = w_wr & (w_idx == REG_STATUS) & bus.sel[0]
                        & bus.dat_mosi[c_status_match_bit];

    always_comb begin
        w_ctrl_word                              = '0;
        w_ctrl_word[c_ctrl_en_bit]               = r_en;
        w_ctrl_word[c_ctrl_auto_bit]             = r_auto;
        w_ctrl_word[c_ctrl_irq_en_bit]           = r_irq_en;
        w_ctrl_word[c_ctrl_psc_lsb +: PSC_W]     = r_psc;
    end

    assign w_ctrl_new    = f_merge(w_ctrl_word, bus.dat_mosi, bus.sel);
    assign w_psc_new     = w_ctrl_new[c_ctrl_psc_lsb +: PSC_W];
    assign w_psc_restart = w_wr_ctrl & (w_psc_new != r_psc);

    always_comb begin
        w_rd_data = '0;
        case (w_idx)
            REG_CTRL:    w_rd_data = w_ctrl_word;
            REG_COUNT:   w_rd_data = r_count;
            REG_COMPARE: w_rd_data = r_compare;
            REG_STATUS:  w_rd_data[c_status_match_bit] = r_match;
            default:     w_rd_data = '0;
        endcase
    end

    wb_timer_prescaler #(
        .PSC_W    (PSC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (r_en),
        .prescale (r_psc),
        .restart  (w_psc_restart),
        .tick     (w_tick)
    );

    // A bus write to COUNT pre-empts the tick, so no match is taken from it
    assign w_count_tick = (r_auto && (r_count == r_compare)) ? '0 : r_count + 1'b1;
    assign w_match_set  = w_tick & (r_count == r_compare) & ~w_wr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en      <= c_ctrl_field_rst;
            r_auto    <= c_ctrl_field_rst;
            r_irq_en  <= c_ctrl_field_rst;
            r_psc     <= {PSC_W{c_ctrl_field_rst}};
            r_count   <= {WIDTH{c_count_rst_fill}};
            r_compare <= {WIDTH{c_compare_rst_fill}};
            r_match   <= c_status_match_rst;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_ack <= w_req & w_mapped;
            r_err <= w_req & ~w_mapped;
            r_dat <= (w_req & w_mapped & ~bus.we) ? w_rd_data : '0;

            if (w_wr_ctrl) begin
                r_en     <= w_ctrl_new[c_ctrl_en_bit];
                r_auto   <= w_ctrl_new[c_ctrl_auto_bit];
                r_irq_en <= w_ctrl_new[c_ctrl_irq_en_bit];
                r_psc    <= w_psc_new;
            end

            if (w_wr_compare) begin
                r_compare <= f_merge(r_compare, bus.dat_mosi, bus.sel);
            end

            if (w_wr_count) begin
                r_count <= f_merge(r_count, bus.dat_mosi, bus.sel);
            end else if (w_tick) begin
                r_count <= w_count_tick;
            end

            r_match <= w_match_set | (r_match & ~w_match_clr);
            r_irq   <= r_match & r_irq_en;
        end
    end

    // Responses are dropped if the master abandons the cycle
    assign w_ack        = r_ack & bus.cyc;
    assign bus.ack      = w_ack;
    assign bus.err      = r_err & bus.cyc;
    assign bus.dat_miso = w_ack ? r_dat : '0;
    assign bus.stall    = 1'b0;
    assign bus.rty      = 1'b0;
    assign irq          = r_irq;

    assign w_unused = ^{bus.adr[WIDTH-1:5], w_ctrl_new};

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_timer
// Brief    : Self-checking bench for wb_timer against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_wb_timer;

    logic clk;
    logic rst_n;
    logic irq;

    Wishbone_bus #(.WIDTH(32)) bus_if ();

    wb_timer #(
        .WIDTH (32),
        .PSC_W (8)
    ) dut (
        .clk   (clk),
        .rst   (rst_n),
        .bus   (bus_if.S),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state
    logic        m_en, m_auto, m_irq_en, m_match, m_irq, m_ack, m_err;
    logic [7:0]  m_psc, m_pcnt;
    logic [31:0] m_count, m_cmp, m_dat;

    // Response observed at the start of the most recent bus_cycle
    logic        obs_ack, obs_err;
    logic [31:0] obs_dat;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {16'h0, m_psc, 5'b0, m_irq_en, m_auto, m_en};
            3'd1:    return m_count;
            3'd2:    return m_cmp;
            3'd3:    return {31'b0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_irq_en = 0; m_match = 0; m_irq = 0;
        m_ack = 0; m_err = 0; m_psc = 0; m_pcnt = 0;
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_dat = 0;
    endtask

    // Advances the model by one clock with the given bus request applied
    task automatic model_step(input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat);
        logic        req, mapped, wr, tick, hit_count, clr, psc_change;
        logic [2:0]  idx;
        logic [31:0] ctrl_new, nxt_count;
        req        = cyc & stb;
        idx        = adr[4:2];
        mapped     = (adr[1:0] == 2'b00) && (idx < 3'd4);
        wr         = req && mapped && we && (sel != 4'b0);
        tick       = m_en && (m_pcnt == m_psc);
        ctrl_new   = merge(model_read(3'd0), dat, sel);
        psc_change = wr && (idx == 3'd0) && (ctrl_new[15:8] != m_psc);
        hit_count  = wr && (idx == 3'd1);
        clr        = wr && (idx == 3'd3) && sel[0] && dat[0];

        if (hit_count)                               nxt_count = merge(m_count, dat, sel);
        else if (tick && m_count == m_cmp && m_auto) nxt_count = 32'h0;
        else if (tick)                               nxt_count = m_count + 32'd1;
        else                                         nxt_count = m_count;

        m_ack = req && mapped;
        m_err = req && !mapped;
        m_dat = (req && mapped && !we) ? model_read(idx) : 32'h0;
        m_irq = m_match && m_irq_en;
        if (tick && m_count == m_cmp && !hit_count) m_match = 1'b1;
        else if (clr)                               m_match = 1'b0;
        if (!m_en || tick || psc_change) m_pcnt = 8'd0;
        else                             m_pcnt = m_pcnt + 8'd1;
        m_count = nxt_count;
        if (wr && idx == 3'd2) m_cmp = merge(m_cmp, dat, sel);
        if (wr && idx == 3'd0) begin
            m_en     = ctrl_new[0];
            m_auto   = ctrl_new[1];
            m_irq_en = ctrl_new[2];
            m_psc    = ctrl_new[15:8];
        end
    endtask

    // Drives one bus cycle from a negedge, checks this cycle's outputs, ends at next negedge
    task automatic bus_cycle(input logic cyc, input logic stb, input logic we,
                             input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat);
        logic        e_ack, e_err;
        logic [31:0] e_dat;
        bus_if.cyc = cyc; bus_if.stb = stb; bus_if.we = we;
        bus_if.adr = adr; bus_if.sel = sel; bus_if.dat_mosi = dat;
        #1;
        obs_ack = bus_if.ack; obs_err = bus_if.err; obs_dat = bus_if.dat_miso;
        e_ack = m_ack & cyc;
        e_err = m_err & cyc;
        e_dat = e_ack ? m_dat : 32'h0;
        n_chk++;
        if (obs_ack !== e_ack || obs_err !== e_err || obs_dat !== e_dat) begin
            n_err++;
            $display("FAIL resp @%0t: ack/err/dat got %b/%b/%h expected %b/%b/%h",
                     $time, obs_ack, obs_err, obs_dat, e_ack, e_err, e_dat);
        end
        n_chk++;
        if (irq !== m_irq) begin
            n_err++;
            $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
        end
        n_chk++;
        if (bus_if.stall !== 1'b0 || bus_if.rty !== 1'b0) begin
            n_err++;
            $display("FAIL stall_rty @%0t: got %b/%b expected 0/0", $time, bus_if.stall, bus_if.rty);
        end
        model_step(cyc, stb, we, adr, sel, dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bus_cycle(1, 1, 1, adr, sel, dat);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] adr, output logic [31:0] data);
        bus_cycle(1, 1, 0, adr, 4'hF, 32'h0);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        data = obs_dat;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_vals [4];
        exp_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        rst_n = 0;
        bus_if.cyc = 0; bus_if.stb = 0; bus_if.we = 0;
        bus_if.adr = 0; bus_if.sel = 0; bus_if.dat_mosi = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (bus_if.ack !== 1'b0 || bus_if.err !== 1'b0 || irq !== 1'b0 || bus_if.dat_miso !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ack/err/irq/dat got %b/%b/%b/%h expected 0/0/0/0",
                     bus_if.ack, bus_if.err, irq, bus_if.dat_miso);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            do_read(32'(i * 4), v);
            n_chk++;
            if (v !== exp_vals[i]) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, v, exp_vals[i]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        bus_cycle(1, 1, 1, 32'h0, 4'hF, 32'h0000_0301);
        repeat (20) bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        do_read(32'h4, v);
        n_chk++;
        if (v !== 32'd5) begin
            n_err++;
            $display("FAIL prescale_count: got %h expected %h", v, 32'd5);
        end
        do_write(32'h0, 4'hF, 32'h0);
    endtask

    task automatic test_auto_reload();
        logic [31:0] vals [8];
        logic [31:0] v, nxt;
        do_write(32'hC, 4'hF, 32'h1);
        do_write(32'h8, 4'hF, 32'h2);
        do_write(32'h4, 4'hF, 32'h0);
        do_write(32'h0, 4'hF, 32'h0000_0007);
        for (int i = 0; i < 9; i++) begin
            bus_cycle(1, i < 8, 0, 32'h4, 4'hF, 32'h0);
            if (i > 0) vals[i-1] = obs_dat;
        end
        for (int k = 0; k < 7; k++) begin
            nxt = (vals[k] == 32'd2) ? 32'd0 : vals[k] + 32'd1;
            n_chk++;
            if (vals[k+1] !== nxt || vals[k] > 32'd2) begin
                n_err++;
                $display("FAIL reload_seq%0d: got %h expected %h", k, vals[k+1], nxt);
            end
        end
        n_chk++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL reload_irq_set: got %b expected 1", irq);
        end
        do_write(32'h0, 4'hF, 32'h0000_0006);
        do_write(32'hC, 4'hF, 32'h1);
        bus_cycle(0, 0, 0, 32'h0, 4'h0, 32'h0);
        n_chk++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reload_irq_clear: got %b expected 0", irq);
        end
        do_read(32'hC, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL reload_status_clear: got %h expected 0", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_vals [4];
        exp_vals = '{32'h0000_0502, 32'h0000_1234, 32'h0000_ABCD, 32'h0};
        do_write(32'h0, 4'hF, 32'h0000_0502);
        do_write(32'h4, 4'hF, 32'h0000_1234);
        do_write(32'h8, 4'hF, 32'h0000_ABCD);
        do_write(32'hC, 4'hF, 32'h1);
        for (int i = 0; i < 5; i++) begin
            bus_cycle(1, i < 4, 0, 32'((i % 4) * 4), 4'hF, 32'h0);
            if (i > 0) begin
                n_chk++;
                if (obs_ack !== 1'b1 || obs_dat !== exp_vals[i-1]) begin
                    n_err++;
                    $display("FAIL b2b_read%0d: ack/dat got %b/%h expected 1/%h",
                             i - 1, obs_ack, obs_dat, exp_vals[i-1]);
                end
            end
        end
    endtask

    task automatic test_err();
        logic [31:0] v;
        logic [31:0] exp_vals [3];
        exp_vals = '{32'h0000_0502, 32'h0000_1234, 32'h0000_ABCD};
        bus_cycle(1, 1, 0, 32'h14, 4'hF, 32'h0);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        n_chk++;
        if (obs_err !== 1'b1 || obs_ack !== 1'b0 || obs_dat !== 32'h0) begin
            n_err++;
            $display("FAIL err_read: err/ack/dat got %b/%b/%h expected 1/0/0", obs_err, obs_ack, obs_dat);
        end
        bus_cycle(1, 1, 1, 32'h2, 4'hF, 32'hFFFF_FFFF);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        n_chk++;
        if (obs_err !== 1'b1 || obs_ack !== 1'b0 || obs_dat !== 32'h0) begin
            n_err++;
            $display("FAIL err_write: err/ack/dat got %b/%b/%h expected 1/0/0", obs_err, obs_ack, obs_dat);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(32'(i * 4), v);
            n_chk++;
            if (v !== exp_vals[i]) begin
                n_err++;
                $display("FAIL err_noeffect%0d: got %h expected %h", i, v, exp_vals[i]);
            end
        end
    endtask

    task automatic test_sel_wrap();
        logic [31:0] v;
        do_write(32'h0, 4'hF, 32'h0);
        do_write(32'h8, 4'hF, 32'd5);
        do_write(32'hC, 4'hF, 32'h1);
        do_write(32'h4, 4'hF, 32'h0);
        do_write(32'h4, 4'b0001, 32'hFFFF_FFFF);
        do_read(32'h4, v);
        n_chk++;
        if (v !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL sel_byte0: got %h expected %h", v, 32'h0000_00FF);
        end
        do_write(32'h4, 4'hF, 32'hFFFF_FFFF);
        bus_cycle(1, 1, 1, 32'h0, 4'hF, 32'h1);
        bus_cycle(1, 1, 1, 32'h0, 4'hF, 32'h0);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        do_read(32'h4, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_count: got %h expected 0", v);
        end
        do_read(32'hC, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_nomatch: got %h expected 0", v);
        end
    endtask

    task automatic test_random();
        logic        cyc, stb, we;
        logic [2:0]  idx;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        int          pick;
        for (int n = 0; n < 400; n++) begin
            cyc  = ($urandom % 8) != 0;
            stb  = ($urandom % 4) != 0;
            we   = ($urandom % 2) != 0;
            idx  = 3'($urandom_range(0, 3));
            pick = int'($urandom % 10);
            if (pick == 0)      adr = 32'h10 + 32'($urandom_range(0, 3) * 4);
            else if (pick == 1) adr = {27'h0, idx, 2'($urandom_range(1, 3))};
            else                adr = {27'h0, idx, 2'b00};
            sel = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
            case (idx)
                3'd0:    dat = {16'h0, 8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
                3'd3:    dat = 32'($urandom);
                default: dat = (($urandom % 8) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 7));
            endcase
            bus_cycle(cyc, stb, we, adr, sel, dat);
        end
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [31:0] exp_vals [4];
        exp_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        do_write(32'h0, 4'hF, 32'h0000_0107);
        bus_cycle(1, 1, 1, 32'h4, 4'hF, 32'h55);
        bus_if.stb = 0;
        rst_n = 0;
        #1;
        n_chk++;
        if (bus_if.ack !== 1'b0 || bus_if.err !== 1'b0 || irq !== 1'b0 || bus_if.dat_miso !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_outputs: ack/err/irq/dat got %b/%b/%b/%h expected 0/0/0/0",
                     bus_if.ack, bus_if.err, irq, bus_if.dat_miso);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        bus_cycle(1, 0, 0, 32'h0, 4'h0, 32'h0);
        n_chk++;
        if (obs_ack !== 1'b0 || obs_err !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_noack: ack/err got %b/%b expected 0/0", obs_ack, obs_err);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(32'(i * 4), v);
            n_chk++;
            if (v !== exp_vals[i]) begin
                n_err++;
                $display("FAIL midrst_reg%0d: got %h expected %h", i, v, exp_vals[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prescale();
        test_auto_reload();
        test_back_to_back();
        test_err();
        test_sel_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
